// File: rtl/fp_posit_acc_pkg.sv
// fp_posit_acc_pkg: FSM states and fixed-point/FP16 constants shared by the posit accumulator files.
package fp_posit_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;
  localparam int ACC_LSB_EXP = -28;
  localparam int FP16_BIAS = 15;
  localparam logic [15:0] FP16_MAX_MAG = 16'h7BFF;
  localparam int ALIGN_OFFSET = 16;
endpackage

// File: rtl/fp_posit_acc_normalize.sv
// fp16_normalize: converts a signed fixed-point accumulator (LSB 2^-28) to truncated FP16; acc in, result out.
module fp16_normalize
  import fp_posit_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 56
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [15:0]          result
);
  localparam int PW = $clog2(ACC_WIDTH);
  localparam logic signed [PW+1:0] E_OFF = (PW+2)'(ACC_LSB_EXP + FP16_BIAS);
  logic sign;
  logic [ACC_WIDTH-1:0] mag;
  logic [PW-1:0] p;
  logic signed [PW+1:0] e;
  logic [9:0] frac;
  always_comb begin
    sign = acc[ACC_WIDTH-1];
    mag = sign ? ACC_WIDTH'(-acc) : ACC_WIDTH'(acc);
    p = '0;
    for (int i = 0; i < ACC_WIDTH; i++) if (mag[i]) p = PW'(i);
    frac = 10'({mag, 10'b0} >> p);
    e = $signed({2'b00, p}) + E_OFF;
    result = (mag == '0 || e <= 0) ? 16'h0000
           : (e >= 31) ? {sign, FP16_MAX_MAG[14:0]}
           : {sign, e[4:0], frac};
  end
endmodule

// File: rtl/fp_posit_acc.sv
// fp_posit_acc: exact fixed-point accumulation of multiplier products with FP16 output and ready/valid handshake.
// Ports: start/acc_len begin a run; in_valid/sign_in/exp_in/mantissa_in deliver products;
// result/out_valid/out_ready hand off the FP16 sum; busy flags non-IDLE; drop pulses on discarded products.
module fp_posit_acc
  import fp_posit_acc_pkg::*;
#(
  parameter int EXP_WIDTH = 5,
  parameter int PROD_MAN_WIDTH = 14,
  parameter int ACC_WIDTH = 56,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      acc_len,
  input  logic                      in_valid,
  input  logic                      sign_in,
  input  logic [EXP_WIDTH-1:0]      exp_in,
  input  logic [PROD_MAN_WIDTH-1:0] mantissa_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               result,
  output logic                      busy,
  output logic                      drop
);
  state_t state;
  logic signed [ACC_WIDTH-1:0] acc, aligned, prod;
  logic [CNT_WIDTH-1:0] count;
  logic [5:0] sh;
  logic [15:0] norm_result;
  always_comb begin
    sh = 6'($signed(exp_in) + ALIGN_OFFSET);
    aligned = ACC_WIDTH'(mantissa_in) << sh;
    prod = sign_in ? -aligned : aligned;
  end
  fp16_normalize #(.ACC_WIDTH(ACC_WIDTH)) u_norm (.acc(acc), .result(norm_result));
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      result <= 16'h0000;
      out_valid <= 1'b0;
      drop <= 1'b0;
    end else begin
      drop <= in_valid && state != ACCUM;
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          count <= acc_len;
          state <= acc_len == '0 ? NORM : ACCUM;
        end
        ACCUM: if (in_valid) begin
          acc <= acc + prod;
          count <= count - 1'b1;
          if (count == CNT_WIDTH'(1)) state <= NORM;
        end
        NORM: begin
          result <= norm_result;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_posit_acc.sv
// tb_fp_posit_acc: directed self-checking bench for fp_posit_acc.
module tb_fp_posit_acc;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, sign_in = 0, out_ready = 0;
  logic [7:0] acc_len = 0;
  logic [4:0] exp_in = 0;
  logic [13:0] mantissa_in = 0;
  logic out_valid, busy, drop;
  logic [15:0] result;
  int checks = 0, errors = 0;

  fp_posit_acc dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len), .in_valid(in_valid),
    .sign_in(sign_in), .exp_in(exp_in), .mantissa_in(mantissa_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1; acc_len = len; tick; start = 0;
  endtask

  task automatic push(input logic s, input logic [4:0] e, input logic [13:0] m);
    in_valid = 1; sign_in = s; exp_in = e; mantissa_in = m; tick; in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
  endtask

  task automatic release_out;
    out_ready = 1; tick; out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick; tick; rst = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
  endtask

  task automatic test_single;
    do_start(8'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    push(0, 5'd0, 14'h1000);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", out_valid); end
    checks++; if (result !== 16'h3C00) begin errors++; $display("FAIL single_result got %h want 3c00", result); end
    release_out;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_release_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_release_busy got %b want 0", busy); end
  endtask

  task automatic test_sum;
    int n;
    logic [15:0] exp_res [4] = '{16'h4000, 16'h0000, 16'h3E00, 16'h0000};
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin do_start(8'd2); push(0, 5'd0, 14'h1000); push(0, 5'd0, 14'h1000); end
        1: begin do_start(8'd2); push(0, 5'd0, 14'h1000); push(1, 5'd0, 14'h1000); end
        2: begin do_start(8'd1); push(0, 5'd0, 14'h1800); end
        default: begin do_start(8'd1); push(0, 5'b10000, 14'h0001); end
      endcase
      wait_out(n);
      checks++; if (n >= 20) begin errors++; $display("FAIL sum_timeout case %0d got no out_valid want out_valid", t); end
      checks++; if (result !== exp_res[t]) begin errors++; $display("FAIL sum_result case %0d got %h want %h", t, result, exp_res[t]); end
      release_out;
    end
  endtask

  task automatic test_saturation;
    int n;
    do_start(8'd1);
    push(1, 5'd15, 14'h3FFF);
    wait_out(n);
    checks++; if (n >= 20) begin errors++; $display("FAIL sat_timeout got no out_valid want out_valid"); end
    checks++; if (result !== 16'hFBFF) begin errors++; $display("FAIL sat_result got %h want fbff", result); end
    release_out;
  endtask

  task automatic test_backpressure;
    int n;
    do_start(8'd1);
    push(0, 5'd0, 14'h1000);
    wait_out(n);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) in_valid = 1;
      start = (c == 3);
      tick;
      in_valid = 0;
      start = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b want 1", c, out_valid); end
      checks++; if (result !== 16'h3C00) begin errors++; $display("FAIL bp_result cycle %0d got %h want 3c00", c, result); end
      checks++; if (drop !== (c == 1)) begin errors++; $display("FAIL bp_drop cycle %0d got %b want %b", c, drop, c == 1); end
    end
    release_out;
    do_start(8'd1);
    push(0, 5'd1, 14'h1000);
    wait_out(n);
    checks++; if (result !== 16'h4000) begin errors++; $display("FAIL bp_next_result got %h want 4000", result); end
    release_out;
  endtask

  task automatic test_reset_mid;
    int n;
    do_start(8'd4);
    push(0, 5'd0, 14'h1000);
    push(0, 5'd0, 14'h1000);
    rst = 1; tick; rst = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rstmid_result got %h want 0000", result); end
    do_start(8'd1);
    push(0, 5'd0, 14'h1000);
    wait_out(n);
    checks++; if (result !== 16'h3C00) begin errors++; $display("FAIL rstmid_fresh got %h want 3c00", result); end
    release_out;
  endtask

  task automatic test_zero_len;
    int n;
    do_start(8'd1);
    push(0, 5'd1, 14'h1000);
    wait_out(n);
    release_out;
    do_start(8'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b want 1", busy); end
    wait_out(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", n); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL zero_result got %h want 0000", result); end
    release_out;
  endtask

  initial begin
    test_reset;
    test_single;
    test_sum;
    test_saturation;
    test_backpressure;
    test_reset_mid;
    test_zero_len;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
